// File: rtl/lfsr_rng_multich.sv
// Multi-channel Fibonacci XNOR-LFSR random source with seed programming, warm-up discard,
// valid/ready backpressure, lock-up seed rejection and an accepted-word counter.
module lfsr_rng_multich #(
    parameter int                N_CH         = 4,
    parameter int                LFSR_W       = 48,
    parameter int                OUT_W        = 16,
    parameter int                WARMUP_CYC   = 0,
    parameter logic [LFSR_W-1:0] DEFAULT_SEED = LFSR_W'(1),
    parameter int                CNT_W        = 32,
    localparam int               SCH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   operation_start,
    input  logic                   seed_wr,
    input  logic [SCH_W-1:0]       seed_ch,
    input  logic [LFSR_W-1:0]      seed,
    input  logic                   rnd_ready,
    output logic [N_CH*OUT_W-1:0]  rnd_out,
    output logic                   rnd_valid,
    output logic [CNT_W-1:0]       sample_cnt,
    output logic [N_CH-1:0]        lockup_err,
    output logic [1:0]             fsm_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    // Tap sets as bit masks (bit k-1 for 1-indexed tap k), so one XNOR-reduce serves every length.
    localparam logic [63:0] TAPS_32  = (64'd1 << 31) | (64'd1 << 21) | (64'd1 << 1)  | 64'd1;
    localparam logic [63:0] TAPS_48  = (64'd1 << 47) | (64'd1 << 46) | (64'd1 << 20) | (64'd1 << 19);
    localparam logic [63:0] TAPS_64  = (64'd1 << 63) | (64'd1 << 62) | (64'd1 << 60) | (64'd1 << 59);
    localparam logic [63:0] TAPS_SEL = (LFSR_W == 32) ? TAPS_32 : (LFSR_W == 48) ? TAPS_48 : TAPS_64;
    localparam logic [LFSR_W-1:0] TAP_MASK = TAPS_SEL[LFSR_W-1:0];

    localparam int              WC_W      = (WARMUP_CYC > 1) ? $clog2(WARMUP_CYC) : 1;
    localparam logic [WC_W-1:0] WARM_LAST = WC_W'((WARMUP_CYC > 0) ? (WARMUP_CYC - 1) : 0);

    if (!(LFSR_W == 32 || LFSR_W == 48 || LFSR_W == 64)) begin : gBadLfsrW
        $error("lfsr_rng_multich: LFSR_W must be 32, 48 or 64");
    end
    if (OUT_W < 1 || OUT_W > LFSR_W) begin : gBadOutW
        $error("lfsr_rng_multich: OUT_W must be within 1..LFSR_W");
    end
    for (genvar g = 0; g < N_CH; g++) begin : gSeedChk
        if ((DEFAULT_SEED ^ LFSR_W'(g)) == {LFSR_W{1'b1}}) begin : gLockSeed
            $error("lfsr_rng_multich: a default channel seed is the all-ones lock-up state");
        end
    end

    state_t            r_state;
    state_t            w_stateNext;
    logic              w_advance;
    logic              w_idle;
    logic              w_seedOnes;
    logic [N_CH-1:0]   w_hit;
    logic [LFSR_W-1:0] r_seedReg  [N_CH];
    logic [LFSR_W-1:0] r_lfsr     [N_CH];
    logic [LFSR_W-1:0] w_seedNext [N_CH];
    logic [LFSR_W-1:0] w_lfsrAdv  [N_CH];
    logic [CNT_W-1:0]  r_sampleCnt;
    logic [WC_W-1:0]   r_warmCnt;
    logic [N_CH-1:0]   r_lockErr;

    function automatic logic [LFSR_W-1:0] advanceWord(input logic [LFSR_W-1:0] s);
        logic [LFSR_W-1:0] v;
        v = s;
        for (int i = 0; i < OUT_W; i++) begin
            v = {v[LFSR_W-2:0], ~^(v & TAP_MASK)};
        end
        return v;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Dropping operation_start always wins over advancing in WARMUP/RUN.
    always_comb begin
        w_stateNext = r_state;
        w_advance   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (operation_start) begin
                    w_stateNext = (WARMUP_CYC > 0) ? ST_WARMUP : ST_RUN;
                end
            end
            ST_WARMUP: begin
                if (!operation_start) begin
                    w_stateNext = ST_IDLE;
                end else begin
                    w_advance = 1'b1;
                    if (r_warmCnt == WARM_LAST) begin
                        w_stateNext = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (!operation_start) begin
                    w_stateNext = ST_IDLE;
                end else begin
                    w_advance = rnd_ready;
                end
            end
            default: w_stateNext = ST_IDLE;
        endcase
    end

    assign w_idle     = (r_state == ST_IDLE);
    assign w_seedOnes = &seed;

    // Out-of-range seed_ch decodes to no channel, so such writes and errors simply vanish.
    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            w_hit[c]      = (seed_ch == SCH_W'(c));
            w_seedNext[c] = r_seedReg[c];
            if (w_idle && seed_wr && !w_seedOnes && w_hit[c]) begin
                w_seedNext[c] = seed;
            end
            w_lfsrAdv[c]  = advanceWord(r_lfsr[c]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int c = 0; c < N_CH; c++) begin
                r_seedReg[c] <= DEFAULT_SEED ^ LFSR_W'(c);
                r_lfsr[c]    <= '0;
            end
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (w_idle) begin
                    r_seedReg[c] <= w_seedNext[c];
                    r_lfsr[c]    <= operation_start ? w_seedNext[c] : r_seedReg[c];
                end else if (w_advance) begin
                    r_lfsr[c] <= w_lfsrAdv[c];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sampleCnt <= '0;
            r_warmCnt   <= '0;
            r_lockErr   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_warmCnt <= '0;
                    if (operation_start) begin
                        r_sampleCnt <= '0;
                    end
                end
                ST_WARMUP: begin
                    if (w_advance) begin
                        r_warmCnt <= r_warmCnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (w_advance) begin
                        r_sampleCnt <= r_sampleCnt + 1'b1;
                    end
                end
                default: ;
            endcase
            if (w_idle && seed_wr && w_seedOnes) begin
                r_lockErr <= r_lockErr | w_hit;
            end
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : gOut
        assign rnd_out[g*OUT_W +: OUT_W] = r_lfsr[g][LFSR_W-1 -: OUT_W];
    end

    assign rnd_valid  = (r_state == ST_RUN);
    assign sample_cnt = r_sampleCnt;
    assign lockup_err = r_lockErr;
    assign fsm_state  = r_state;

endmodule

// File: tb/tb_lfsr_rng_multich.sv
// Randomized scoreboard bench for lfsr_rng_multich: a bit-sequence recurrence model predicts every
// accepted word; a second instance with WARMUP_CYC=4 covers the warm-up timing.
module tb_lfsr_rng_multich;

    localparam int          N_CH     = 4;
    localparam int          LFSR_W   = 48;
    localparam int          OUT_W    = 16;
    localparam int          CNT_W    = 32;
    localparam logic [47:0] DEF_SEED = 48'h1;
    localparam logic [47:0] ALL_ONES = {48{1'b1}};

    typedef struct {
        logic [63:0] word;
        logic [31:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        operationStart;
    logic        seedWr;
    logic [1:0]  seedCh;
    logic [47:0] seedVal;
    logic        rndReady;
    logic [63:0] rndOut;
    logic        rndValid;
    logic [31:0] sampleCnt;
    logic [3:0]  lockupErr;
    logic [1:0]  fsmState;

    logic        start1;
    logic        ready1;
    logic        wr1;
    logic [63:0] rndOut1;
    logic        rndValid1;
    logic [31:0] sampleCnt1;
    logic [3:0]  lockupErr1;
    logic [1:0]  fsmState1;

    int          nCompared = 0;
    int          nFailed   = 0;
    int          acceptCnt = 0;
    logic [47:0] modelSeed [N_CH];
    logic [3:0]  modelLock;
    bit          seqBits   [N_CH][$];
    exp_t        expQ      [$];

    always #5 clk = ~clk;

    lfsr_rng_multich #(
        .N_CH(N_CH), .LFSR_W(LFSR_W), .OUT_W(OUT_W), .WARMUP_CYC(0),
        .DEFAULT_SEED(DEF_SEED), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .operation_start(operationStart), .seed_wr(seedWr),
        .seed_ch(seedCh), .seed(seedVal), .rnd_ready(rndReady), .rnd_out(rndOut),
        .rnd_valid(rndValid), .sample_cnt(sampleCnt), .lockup_err(lockupErr), .fsm_state(fsmState)
    );

    lfsr_rng_multich #(
        .N_CH(N_CH), .LFSR_W(LFSR_W), .OUT_W(OUT_W), .WARMUP_CYC(4),
        .DEFAULT_SEED(DEF_SEED), .CNT_W(CNT_W)
    ) dutWarm (
        .clk(clk), .rst(rst), .operation_start(start1), .seed_wr(wr1),
        .seed_ch(seedCh), .seed(seedVal), .rnd_ready(ready1), .rnd_out(rndOut1),
        .rnd_valid(rndValid1), .sample_cnt(sampleCnt1), .lockup_err(lockupErr1), .fsm_state(fsmState1)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic start, input logic ready, input logic wr,
                                 input logic [1:0] ch, input logic [47:0] sd);
        operationStart = start;
        rndReady       = ready;
        seedWr         = wr;
        seedCh         = ch;
        seedVal        = sd;
        @(posedge clk);
        #1;
    endtask

    function automatic void modelDefaults();
        for (int c = 0; c < N_CH; c++) modelSeed[c] = DEF_SEED ^ 48'(c);
        modelLock = '0;
    endfunction

    function automatic void modelWrite(input logic [1:0] ch, input logic [47:0] sd);
        if (sd == ALL_ONES) modelLock[ch] = 1'b1;
        else                modelSeed[ch] = sd;
    endfunction

    // Stream view: seqBits[c][i] is x(i-48); the seed supplies x(-48)..x(-1), MSB oldest.
    function automatic void modelStart();
        for (int c = 0; c < N_CH; c++) begin
            seqBits[c].delete();
            for (int i = 0; i < 48; i++) seqBits[c].push_back(modelSeed[c][47-i]);
        end
    endfunction

    // x(t) = ~(x(t-48) ^ x(t-47) ^ x(t-21) ^ x(t-20)); word k is x(16k-48)..x(16k-33), oldest as MSB.
    function automatic logic [15:0] expChan(input int c, input int k);
        logic [15:0] w;
        int          t;
        while (seqBits[c].size() < 16*k + 16) begin
            t = seqBits[c].size() - 48;
            seqBits[c].push_back(~(seqBits[c][t] ^ seqBits[c][t+1] ^ seqBits[c][t+27] ^ seqBits[c][t+28]));
        end
        for (int j = 0; j < 16; j++) w[15-j] = seqBits[c][16*k + j];
        return w;
    endfunction

    function automatic logic [63:0] expWord(input int k);
        logic [63:0] w;
        for (int c = 0; c < N_CH; c++) w[c*16 +: 16] = expChan(c, k);
        return w;
    endfunction

    task automatic startRun(input bit withWr, input logic [1:0] ch, input logic [47:0] sd);
        if (withWr) modelWrite(ch, sd);
        modelStart();
        acceptCnt = 0;
        applyStimulus(1'b1, 1'b0, withWr, ch, sd);
        checkOutput("run entered", 64'(fsmState), 64'd2);
        checkOutput("valid in run", 64'(rndValid), 64'd1);
        checkOutput("count cleared on start", 64'(sampleCnt), 64'd0);
    endtask

    task automatic acceptWords(input int n, input int pct);
        int done;
        bit rdy;
        done = 0;
        while (done < n) begin
            rdy = ($urandom_range(99) < pct);
            if (rdy) begin
                expQ.push_back('{expWord(acceptCnt), 32'(acceptCnt)});
                acceptCnt++;
                done++;
            end
            applyStimulus(1'b1, rdy, 1'b0, 2'd0, 48'd0);
        end
    endtask

    task automatic holdCycles(input int m);
        for (int i = 0; i < m; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 48'd0);
            checkOutput("hold word", rndOut, expWord(acceptCnt));
            checkOutput("hold count", 64'(sampleCnt), 64'(acceptCnt));
        end
    endtask

    task automatic stopRun();
        applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 48'd0);
        checkOutput("stop to idle", 64'(fsmState), 64'd0);
        checkOutput("valid after stop", 64'(rndValid), 64'd0);
        checkOutput("count held at stop", 64'(sampleCnt), 64'(acceptCnt));
        applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 48'd0);
        checkOutput("count held in idle", 64'(sampleCnt), 64'(acceptCnt));
    endtask

    task automatic writeSeed(input logic [1:0] ch, input logic [47:0] sd);
        modelWrite(ch, sd);
        applyStimulus(1'b0, 1'b0, 1'b1, ch, sd);
        checkOutput("lockup flags after write", 64'(lockupErr), 64'(modelLock));
    endtask

    task automatic pulseReset();
        operationStart = 1'b0;
        rndReady       = 1'b0;
        seedWr         = 1'b0;
        rst            = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        modelDefaults();
        checkOutput("reset state", 64'(fsmState), 64'd0);
        checkOutput("reset valid", 64'(rndValid), 64'd0);
        checkOutput("reset count", 64'(sampleCnt), 64'd0);
        checkOutput("reset lockup", 64'(lockupErr), 64'd0);
    endtask

    task automatic monitorLoop();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst && rndValid && rndReady) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected handshake valid", 64'(rndValid), 64'd0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("scoreboard word", rndOut, e.word);
                    checkOutput("scoreboard count", 64'(sampleCnt), 64'(e.cnt));
                end
            end
        end
    endtask

    initial begin
        rst = 1'b0; operationStart = 1'b0; seedWr = 1'b0; seedCh = '0; seedVal = '0; rndReady = 1'b0;
        start1 = 1'b0; ready1 = 1'b0; wr1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        fork
            monitorLoop();
        join_none
        pulseReset();

        // 1000 back-to-back words from the default seeds.
        startRun(1'b0, 2'd0, 48'd0);
        acceptWords(1000, 100);
        stopRun();
        checkOutput("count after 1000 words", 64'(sampleCnt), 64'd1000);

        // All-ones seed is rejected and flagged on its channel only.
        writeSeed(2'd2, ALL_ONES);
        checkOutput("lockup ch2 only", 64'(lockupErr), 64'h4);

        // Zero seed on ch0 plus random seeds elsewhere, random backpressure and a long stall.
        writeSeed(2'd0, 48'd0);
        writeSeed(2'd1, {16'($urandom()), $urandom()});
        writeSeed(2'd3, {16'($urandom()), $urandom()});
        startRun(1'b0, 2'd0, 48'd0);
        checkOutput("zero seed first word", 64'(rndOut[15:0]), 64'h0);
        acceptWords(1, 100);
        checkOutput("zero seed word 1", 64'(rndOut[15:0]), 64'h0);
        acceptWords(2, 100);
        checkOutput("zero seed word 3", 64'(rndOut[15:0]), 64'hFFFF);
        acceptWords(150, 50);
        holdCycles(5);
        acceptWords(1, 100);
        applyStimulus(1'b1, 1'b0, 1'b1, 2'd0, {16'($urandom()), $urandom()});
        applyStimulus(1'b1, 1'b0, 1'b1, 2'd1, ALL_ONES);
        checkOutput("run seed write ignored", rndOut, expWord(acceptCnt));
        checkOutput("run lockup write ignored", 64'(lockupErr), 64'(modelLock));
        acceptWords(20, 70);
        stopRun();

        // Seed write in the same cycle as start, then reset in the middle of the run.
        startRun(1'b1, 2'd3, {16'($urandom()), $urandom()});
        acceptWords(100, 60);
        checkOutput("lockup sticky across runs", 64'(lockupErr), 64'h4);
        pulseReset();
        startRun(1'b0, 2'd0, 48'd0);
        acceptWords(20, 80);
        stopRun();

        // Warm-up instance: valid rises only after edge 4, first word is 64 steps in.
        modelDefaults();
        modelStart();
        start1 = 1'b1;
        for (int e = 0; e < 5; e++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("warmup valid edge %0d", e), 64'(rndValid1), (e == 4) ? 64'd1 : 64'd0);
            checkOutput($sformatf("warmup state edge %0d", e), 64'(fsmState1), (e < 4) ? 64'd1 : 64'd2);
        end
        checkOutput("warmup first word", rndOut1, expWord(4));
        checkOutput("warmup count", 64'(sampleCnt1), 64'd0);
        ready1 = 1'b1;
        @(posedge clk);
        #1;
        ready1 = 1'b0;
        checkOutput("warmup second word", rndOut1, expWord(5));
        checkOutput("warmup count after accept", 64'(sampleCnt1), 64'd1);
        start1 = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("warmup instance idle", 64'(fsmState1), 64'd0);
        checkOutput("warmup instance lockup", 64'(lockupErr1), 64'd0);

        @(posedge clk);
        #1;
        checkOutput("scoreboard drained", 64'(expQ.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
        $finish;
    end

endmodule
